dsp_simd_alu: RTL and testbench

- Behavioural model of the DSP48E2 datapath subset used by the dsp_add_* primitives: 48-bit SIMD adder/subtractor with no multiplier.
- Four operand muxes (W/X/Y/Z) are selected by OPMODE. ALUMODE selects add or subtract.
- The P output register is optional. SIMD lane carry isolation is supported.
- Used for simulation and equivalence checking of the adder wrappers in place of the vendor primitive.

---
 rtl/dsp_simd_pkg.sv | 43 ++++
 rtl/dsp_simd_lane.sv | 38 +++
 rtl/dsp_simd_alu.sv | 115 +++++++++++
 tb/tb_dsp_simd_alu.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_simd_pkg.sv
// Shared encodings for the DSP48E2-style SIMD adder: OPMODE mux fields,
// ALUMODE operations and the SIMD lane-split mode.
package dsp_simd_pkg;

  localparam logic [1:0] X_ZERO = 2'b00;
  localparam logic [1:0] X_P    = 2'b10;
  localparam logic [1:0] X_AB   = 2'b11;

  localparam logic [1:0] Y_ONES = 2'b10;
  localparam logic [1:0] Y_C    = 2'b11;

  localparam logic [2:0] Z_P    = 3'b010;
  localparam logic [2:0] Z_C    = 3'b011;
  localparam logic [2:0] Z_P17  = 3'b110;

  localparam logic [1:0] W_P    = 2'b01;
  localparam logic [1:0] W_C    = 2'b11;

  localparam logic [3:0] ALUMODE_ADD = 4'b0000;
  localparam logic [3:0] ALUMODE_SUB = 4'b0011;

  typedef enum logic [1:0] {
    SIMD_ONE48,
    SIMD_TWO24,
    SIMD_FOUR12
  } simd_mode_e;

  // Unrecognised mode strings fall back to a single 48-bit lane.
  function automatic simd_mode_e simd_mode_of(input string s);
    if (s == "FOUR12") return SIMD_FOUR12;
    if (s == "TWO24")  return SIMD_TWO24;
    return SIMD_ONE48;
  endfunction

  function automatic int lane_count(input simd_mode_e m);
    case (m)
      SIMD_TWO24:  return 2;
      SIMD_FOUR12: return 4;
      default:     return 1;
    endcase
  endfunction

endpackage

// File: rtl/dsp_simd_lane.sv
// One SIMD lane: Z plus or minus the sum of W, X, Y and carry-in, with a
// lane-local carry (add) or borrow (subtract) flag.
module dsp_simd_lane #(
  parameter int WIDTH = 48
) (
  input  logic [WIDTH-1:0] z,
  input  logic [WIDTH-1:0] w,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic [WIDTH-1:0] res,
  output logic             cout
);

  // Three operands plus carry-in need two guard bits; one more keeps Z+addend exact.
  localparam int EW = WIDTH + 3;

  logic [EW-1:0] addend;
  logic [EW-1:0] total;
  logic          unused_hi;

  // NOTE: every output of a combinational block is assigned on every path, so no latch is inferred.
  always_comb begin
    addend = EW'(w) + EW'(x) + EW'(y) + EW'(cin);
    if (sub) begin
      total = EW'(z) - addend;
      cout  = (addend > EW'(z));
    end else begin
      total = EW'(z) + addend;
      cout  = total[WIDTH];
    end
    res = total[WIDTH-1:0];
  end

  assign unused_hi = ^total[EW-1:WIDTH+1];

endmodule

// File: rtl/dsp_simd_alu.sv
// DSP48E2 adder-only datapath model: W/X/Y/Z operand muxes, SIMD lanes with
// carry isolation, and an optional P/CARRYOUT output register.
module dsp_simd_alu
  import dsp_simd_pkg::*;
#(
  parameter string USE_SIMD = "ONE48",
  parameter int    PREG     = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cep,
  input  logic [29:0] a,
  input  logic [17:0] b,
  input  logic [47:0] c,
  input  logic        carryin,
  input  logic [8:0]  opmode,
  input  logic [3:0]  alumode,
  output logic [47:0] p,
  output logic [3:0]  carryout
);

  localparam simd_mode_e MODE      = simd_mode_of(USE_SIMD);
  localparam int         LANES     = lane_count(MODE);
  localparam int         LW        = 48 / LANES;
  localparam int         CO_STRIDE = 4 / LANES;

  logic [47:0]      ab;
  logic [47:0]      p_fb;
  logic [47:0]      x_mux, y_mux, z_mux, w_mux;
  logic [47:0]      p_comb;
  logic [LANES-1:0] lane_co;
  logic [3:0]       co_comb;
  logic             sub;

  assign ab  = {a, b};
  assign sub = (alumode == ALUMODE_SUB);

  always_comb begin
    x_mux = '0;
    y_mux = '0;
    z_mux = '0;
    w_mux = '0;
    case (opmode[1:0])
      X_ZERO:  x_mux = '0;
      X_P:     x_mux = p_fb;
      X_AB:    x_mux = ab;
      default: x_mux = '0;
    endcase
    case (opmode[3:2])
      Y_ONES:  y_mux = '1;
      Y_C:     y_mux = c;
      default: y_mux = '0;
    endcase
    case (opmode[6:4])
      Z_P:     z_mux = p_fb;
      Z_C:     z_mux = c;
      Z_P17:   z_mux = p_fb >> 17;
      default: z_mux = '0;
    endcase
    case (opmode[8:7])
      W_P:     w_mux = p_fb;
      W_C:     w_mux = c;
      default: w_mux = '0;
    endcase
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    dsp_simd_lane #(.WIDTH(LW)) u_lane (
      .z    (z_mux[i*LW +: LW]),
      .w    (w_mux[i*LW +: LW]),
      .x    (x_mux[i*LW +: LW]),
      .y    (y_mux[i*LW +: LW]),
      .cin  ((i == 0) ? carryin : 1'b0),
      .sub  (sub),
      .res  (p_comb[i*LW +: LW]),
      .cout (lane_co[i])
    );
  end

  // Each lane's flag lands on the top bit of its quarter-group of carryout.
  always_comb begin
    co_comb = '0;
    for (int i = 0; i < LANES; i++) begin
      co_comb[(i+1)*CO_STRIDE-1] = lane_co[i];
    end
  end

  if (PREG != 0) begin : g_preg
    logic [47:0] p_q;
    logic [3:0]  co_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        p_q  <= '0;
        co_q <= '0;
      end else if (cep) begin
        p_q  <= p_comb;
        co_q <= co_comb;
      end
    end

    assign p        = p_q;
    assign carryout = co_q;
    assign p_fb     = p_q;
  end else begin : g_comb
    // Without the register there is no feedback path; P encodings read as zero.
    logic unused_ctrl;
    assign unused_ctrl = cep ^ reset ^ clock;
    assign p           = p_comb;
    assign carryout    = co_comb;
    assign p_fb        = '0;
  end

endmodule

// File: tb/tb_dsp_simd_alu.sv
// Scoreboard bench: six dsp_simd_alu instances (three lane splits x PREG 0/1)
// share stimulus and are checked against a lane-arithmetic reference model.
module tb_dsp_simd_alu;

  localparam logic [8:0] OP_AB_C = 9'b00_011_00_11;  // Z=C, X=AB
  localparam logic [8:0] OP_ACC  = 9'b00_010_00_11;  // Z=P, X=AB

  typedef struct packed {
    logic [2:0][47:0] p;
    logic [2:0][3:0]  co;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cep = 1'b0;
  logic        carryin = 1'b0;
  logic [29:0] a = '0;
  logic [17:0] b = '0;
  logic [47:0] c = '0;
  logic [8:0]  opmode = '0;
  logic [3:0]  alumode = '0;

  logic [47:0] p_out  [6];
  logic [3:0]  co_out [6];

  exp_t comb_q[$];
  exp_t reg_q[$];
  logic [47:0] m_p  [3];
  logic [3:0]  m_co [3];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  // Instances 0..2: PREG=0 (ONE48, TWO24, FOUR12); 3..5: PREG=1, same order.
  for (genvar g = 0; g < 6; g++) begin : g_dut
    localparam string MODE = (g % 3 == 0) ? "ONE48" : (g % 3 == 1) ? "TWO24" : "FOUR12";
    dsp_simd_alu #(.USE_SIMD(MODE), .PREG(g / 3)) u_dut (
      .clock    (clock),
      .reset    (reset),
      .cep      (cep),
      .a        (a),
      .b        (b),
      .c        (c),
      .carryin  (carryin),
      .opmode   (opmode),
      .alumode  (alumode),
      .p        (p_out[g]),
      .carryout (co_out[g])
    );
  end

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int lanes_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 2 : 4;
  endfunction

  // Reference: pick operands, then do plain integer arithmetic lane by lane.
  function automatic void ref_model(input int lanes, input logic [47:0] fb, input logic [47:0] ab_v,
                                    input logic [47:0] c_v, input logic cin_v, input logic [8:0] op,
                                    input logic [3:0] alu, output logic [47:0] p_r, output logic [3:0] co_r);
    logic [47:0] xv, yv, zv, wv;
    longint unsigned mask, zi, sumo, r;
    logic [63:0] acc;
    int L;
    xv = (op[1:0] == 2'b10) ? fb : (op[1:0] == 2'b11) ? ab_v : 48'd0;
    yv = (op[3:2] == 2'b10) ? {48{1'b1}} : (op[3:2] == 2'b11) ? c_v : 48'd0;
    zv = (op[6:4] == 3'b010) ? fb : (op[6:4] == 3'b011) ? c_v : (op[6:4] == 3'b110) ? (fb >> 17) : 48'd0;
    wv = (op[8:7] == 2'b01) ? fb : (op[8:7] == 2'b11) ? c_v : 48'd0;
    L    = 48 / lanes;
    mask = (64'd1 << L) - 64'd1;
    acc  = '0;
    co_r = '0;
    for (int i = 0; i < lanes; i++) begin
      zi   = ({16'd0, zv} >> (i * L)) & mask;
      sumo = (({16'd0, wv} >> (i * L)) & mask) + (({16'd0, xv} >> (i * L)) & mask)
           + (({16'd0, yv} >> (i * L)) & mask) + ((i == 0) ? 64'(cin_v) : 64'd0);
      if (alu == 4'b0011) begin
        r = zi - sumo;
        co_r[(i+1)*(4/lanes)-1] = (sumo > zi);
      end else begin
        r = zi + sumo;
        co_r[(i+1)*(4/lanes)-1] = r[L];
      end
      acc = acc | ((r & mask) << (i * L));
    end
    p_r = acc[47:0];
  endfunction

  task automatic check_regs_zero(input string tag);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s_p%0d", tag, k + 3), p_out[k+3], 48'd0);
      check($sformatf("%s_co%0d", tag, k + 3), 48'(co_out[k+3]), 48'd0);
    end
  endtask

  // One stimulus cycle: apply after the edge, push expectations, optionally
  // pull reset low half a cycle later.
  task automatic drive(input logic [47:0] ab_v, input logic [47:0] c_v, input logic cin_v,
                       input logic [8:0] op, input logic [3:0] alu, input logic cep_v,
                       input logic rst_v, input logic mid_rst);
    exp_t e_c, e_r;
    logic [47:0] pr;
    logic [3:0]  cr;
    @(posedge clock);
    #2;
    a       = ab_v[47:18];
    b       = ab_v[17:0];
    c       = c_v;
    carryin = cin_v;
    opmode  = op;
    alumode = alu;
    cep     = cep_v;
    reset   = rst_v;
    for (int k = 0; k < 3; k++) begin
      ref_model(lanes_of(k), 48'd0, ab_v, c_v, cin_v, op, alu, pr, cr);
      e_c.p[k]  = pr;
      e_c.co[k] = cr;
    end
    comb_q.push_back(e_c);
    if (mid_rst) begin
      #3;
      reset = 1'b0;
      #1;
      check_regs_zero("mid_reset");
    end
    for (int k = 0; k < 3; k++) begin
      if (!rst_v || mid_rst) begin
        m_p[k]  = '0;
        m_co[k] = '0;
      end else if (cep_v) begin
        ref_model(lanes_of(k), m_p[k], ab_v, c_v, cin_v, op, alu, pr, cr);
        m_p[k]  = pr;
        m_co[k] = cr;
      end
      e_r.p[k]  = m_p[k];
      e_r.co[k] = m_co[k];
    end
    reg_q.push_back(e_r);
  endtask

  // Combinational instances settle well before the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (comb_q.size() > 0) begin
        e = comb_q.pop_front();
        for (int k = 0; k < 3; k++) begin
          check($sformatf("comb%0d_p", k), p_out[k], e.p[k]);
          check($sformatf("comb%0d_co", k), 48'(co_out[k]), 48'(e.co[k]));
        end
      end
    end
  end

  // Registered instances are sampled just after the capturing edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (reg_q.size() > 0) begin
        e = reg_q.pop_front();
        for (int k = 0; k < 3; k++) begin
          check($sformatf("reg%0d_p", k + 3), p_out[k+3], e.p[k]);
          check($sformatf("reg%0d_co", k + 3), 48'(co_out[k+3]), 48'(e.co[k]));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

  initial begin
    logic [47:0] ab_r, c_r;
    logic [8:0]  op_r;
    logic [3:0]  alu_r;
    int          sel;
    for (int k = 0; k < 3; k++) begin
      m_p[k]  = '0;
      m_co[k] = '0;
    end

    #1;
    check_regs_zero("reset_state");
    repeat (2) @(posedge clock);

    drive({24'd3, 24'd5}, {24'd9, 24'd7}, 1'b0, OP_AB_C, 4'b0000, 1'b1, 1'b1, 1'b0);
    #1;
    check("two24_add_p", p_out[1], {24'd12, 24'd12});
    check("two24_add_co", 48'(co_out[1]), 48'd0);

    drive({24'd2, 24'hFFFFFF}, {24'd4, 24'd1}, 1'b0, OP_AB_C, 4'b0000, 1'b1, 1'b1, 1'b0);
    #1;
    check("two24_iso_p", p_out[1], {24'd6, 24'd0});
    check("two24_iso_co", 48'(co_out[1]), 48'(4'b0010));

    drive(48'd30, 48'd100, 1'b0, OP_AB_C, 4'b0011, 1'b1, 1'b1, 1'b0);
    #1;
    check("one48_sub_p", p_out[0], 48'd70);
    check("one48_sub_co", 48'(co_out[0]), 48'd0);

    drive(48'd100, 48'd30, 1'b0, OP_AB_C, 4'b0011, 1'b1, 1'b1, 1'b0);
    #1;
    check("one48_borrow_p", p_out[0], 48'hFFFF_FFFF_FFBA);
    check("one48_borrow_co", 48'(co_out[0]), 48'(4'b1000));

    drive(48'h001_002_003_FFF, 48'h001_001_001_001, 1'b1, OP_AB_C, 4'b0000, 1'b1, 1'b1, 1'b0);
    #1;
    check("four12_p", p_out[2], 48'h002_003_004_001);
    check("four12_co", 48'(co_out[2]), 48'(4'b0001));

    // Accumulator: count from reset, hold on cep=0, clear mid-count, resume.
    drive(48'd1, 48'd0, 1'b0, OP_ACC, 4'b0000, 1'b1, 1'b0, 1'b0);
    repeat (5) drive(48'd1, 48'd0, 1'b0, OP_ACC, 4'b0000, 1'b1, 1'b1, 1'b0);
    drive(48'd1, 48'd0, 1'b0, OP_ACC, 4'b0000, 1'b0, 1'b1, 1'b0);
    #1;
    check("acc_count5", p_out[3], 48'd5);
    drive(48'd1, 48'd0, 1'b0, OP_ACC, 4'b0000, 1'b0, 1'b1, 1'b0);
    #1;
    check("acc_hold", p_out[3], 48'd5);
    drive(48'd1, 48'd0, 1'b0, OP_ACC, 4'b0000, 1'b1, 1'b1, 1'b0);
    drive(48'd1, 48'd0, 1'b0, OP_ACC, 4'b0000, 1'b1, 1'b1, 1'b1);
    drive(48'd1, 48'd0, 1'b0, OP_ACC, 4'b0000, 1'b1, 1'b1, 1'b0);
    drive(48'd1, 48'd0, 1'b0, OP_ACC, 4'b0000, 1'b1, 1'b1, 1'b0);
    #1;
    check("acc_resume", p_out[3], 48'd1);

    for (int n = 0; n < 300; n++) begin
      op_r  = 9'($urandom_range(0, 511));
      sel   = $urandom_range(0, 3);
      alu_r = (sel == 0) ? 4'b0000 : (sel == 2) ? 4'($urandom) : 4'b0011;
      ab_r  = {16'($urandom), 32'($urandom)};
      c_r   = {16'($urandom), 32'($urandom)};
      if ($urandom_range(0, 7) == 0) ab_r = {48{1'b1}};
      if ($urandom_range(0, 7) == 0) c_r  = {48{1'b1}};
      drive(ab_r, c_r, 1'($urandom), op_r, alu_r, 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 49) != 0), 1'($urandom_range(0, 59) == 0));
    end

    repeat (2) @(posedge clock);
    #3;
    check("comb_q_drained", 48'(comb_q.size()), 48'd0);
    check("reg_q_drained", 48'(reg_q.size()), 48'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
